stim_pattern_gen: RTL
=====================

STIM_PATTERN_GEN -- requirements
Module: stim_pattern_gen

Interface
REQ-001 Parameter WIDTH, default 4, range 1..16: pattern bus width.
REQ-002 Parameter HOLD_CYCLES, default 1000, minimum 1: clock cycles each pattern is held.
REQ-003 Parameter NUM_PATTERNS, default 18, range 1..65535: patterns applied per run; may exceed 2**WIDTH.
REQ-004 Port i_clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 Port i_rst, input, 1: reset, synchronous and active-high.
REQ-006 Port i_start, input, 1: run request, level-sampled each edge.
REQ-007 Port i_pause, input, 1: freezes hold counter while high.
REQ-008 Port i_mode, input, 2: 00 binary, 01 walking-one, 10 gray, 11 reserved (treated as binary).
REQ-009 Port o_pattern, output, WIDTH: stimulus vector driven to the device under test.
REQ-010 Port o_strobe, output, 1: one-cycle pulse in the first cycle each new pattern is valid.
REQ-011 Port o_index, output, 16: ordinal of the current pattern, 0-based.
REQ-012 Port o_busy, output, 1: high in RUN.
REQ-013 Port o_done, output, 1: high in DONE.

Function
REQ-014 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-015 In IDLE or DONE, i_start=1 at an edge SHALL enter RUN at that edge, with o_index=0, o_pattern=P(0), o_strobe=1 and the hold counter=0.
REQ-016 i_mode SHALL be latched on the start edge; changes during RUN SHALL be ignored.
REQ-017 i_start during RUN SHALL be ignored.
REQ-018 In RUN, the hold counter SHALL increment each cycle i_pause=0 and hold its value when i_pause=1.
REQ-019 When the hold counter equals HOLD_CYCLES-1, i_pause=0 and o_index<NUM_PATTERNS-1, the next edge SHALL increment o_index, load P(o_index+1), pulse o_strobe and clear the counter.
REQ-020 When the same condition holds with o_index=NUM_PATTERNS-1, the next edge SHALL enter DONE, holding the last o_pattern and o_index.
REQ-021 Unpaused, each pattern SHALL be valid for exactly HOLD_CYCLES cycles; a run SHALL last NUM_PATTERNS*HOLD_CYCLES cycles from the start edge to DONE.
REQ-022 Binary mode: P(n) = n mod 2**WIDTH, wrapping silently.
REQ-023 Walking-one mode: P(n) = 1 shifted left by (n mod WIDTH).
REQ-024 Gray mode: P(n) = b xor (b>>1), where b = n mod 2**WIDTH.
REQ-025 With HOLD_CYCLES=1, the block SHALL present a new pattern every cycle, with o_strobe high continuously until DONE.
REQ-026 i_pause in IDLE or DONE SHALL have no effect.

Reset
REQ-027 i_rst=1 at an edge SHALL force IDLE, o_pattern=0, o_index=0, o_strobe=0, o_busy=0, o_done=0 and hold counter=0.
REQ-028 Reset SHALL take priority over i_start and i_pause, including mid-run; no partial pattern sequence resumes afterwards.

Configuration
REQ-029 Macro STIM_PATTERN_GEN_GRAY_EN defined: gray mode (i_mode=10) SHALL behave as in REQ-024.
REQ-030 Macro STIM_PATTERN_GEN_GRAY_EN undefined: gray logic SHALL be absent, and i_mode=10 SHALL behave as binary.

Verification
REQ-031 WIDTH=4, HOLD_CYCLES=3, NUM_PATTERNS=18, mode 00, start pulse -> o_pattern 0..15,0,1, each for 3 cycles; 18 strobes; o_done high 54 cycles after the start edge.
REQ-032 WIDTH=4, HOLD_CYCLES=2, NUM_PATTERNS=6, mode 01 -> o_pattern 1,2,4,8,1,2; o_done after 12 cycles.
REQ-033 Macro defined, WIDTH=3, HOLD_CYCLES=1, NUM_PATTERNS=8, mode 10 -> o_pattern 0,1,3,2,6,7,5,4; macro undefined -> 0..7.
REQ-034 HOLD_CYCLES=3, i_pause high 5 cycles during pattern 2 -> pattern 2 valid 8 cycles; total run lengthened by 5.
REQ-035 i_rst during pattern 5 -> next cycle all outputs 0 and IDLE; a subsequent i_start restarts at o_index=0.
REQ-036 i_start held high through RUN -> no restart mid-run; in DONE, still-high i_start -> immediate new run, with o_strobe and P(0).

Source files
------------

// File: rtl/stim_pattern_gen.sv
// Stimulus pattern generator: steps through binary, walking-one or gray patterns, holding each for HOLD_CYCLES clocks.
// Latency: the start edge presents P(0) with a strobe; each following pattern appears on the edge after its predecessor's hold ends.
// Backpressure: none; i_pause freezes the hold counter while in RUN. Optional gray mode is built only when STIM_PATTERN_GEN_GRAY_EN is defined.
module stim_pattern_gen #(
    parameter int WIDTH        = 4,
    parameter int HOLD_CYCLES  = 1000,
    parameter int NUM_PATTERNS = 18
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_pause,
    input  logic [1:0]       i_mode,
    output logic [WIDTH-1:0] o_pattern,
    output logic             o_strobe,
    output logic [15:0]      o_index,
    output logic             o_busy,
    output logic             o_done
);

    // Hold counter needs at least one bit even when every pattern lasts one cycle.
    localparam int              CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [15:0]     LAST_IDX  = 16'(NUM_PATTERNS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] MODE_WALK = 2'b01;
`ifdef STIM_PATTERN_GEN_GRAY_EN
    localparam logic [1:0] MODE_GRAY = 2'b10;
`endif

    logic [1:0]       state;
    logic [1:0]       mode_q;
    logic [CW-1:0]    hold_cnt;
    logic             start_ev;
    logic [15:0]      next_idx;
    logic [1:0]       next_mode;
    logic [WIDTH-1:0] next_bin;
    logic [WIDTH-1:0] next_pat;

    // A start is only honoured outside RUN; it restarts the sequence at index 0.
    assign start_ev  = (state != ST_RUN) && i_start;
    assign next_idx  = start_ev ? 16'd0 : (o_index + 16'd1);
    assign next_mode = start_ev ? i_mode : mode_q;
    assign next_bin  = next_idx[WIDTH-1:0];

    // Pattern for the next index. Walking-one rotates the current one-hot value
    // instead of taking a modulo of the index; the rotate wraps after WIDTH steps.
    always_comb begin
        next_pat = next_bin;
        case (next_mode)
            MODE_WALK: next_pat = start_ev ? WIDTH'(1)
                                           : ((o_pattern << 1) | (o_pattern >> (WIDTH - 1)));
`ifdef STIM_PATTERN_GEN_GRAY_EN
            MODE_GRAY: next_pat = next_bin ^ (next_bin >> 1);
`endif
            default:   next_pat = next_bin;
        endcase
    end

    // Run-control FSM, hold counter and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            mode_q    <= 2'b00;
            hold_cnt  <= '0;
            o_pattern <= '0;
            o_index   <= 16'd0;
            o_strobe  <= 1'b0;
        end else begin
            o_strobe <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ev) begin
                        state     <= ST_RUN;
                        mode_q    <= i_mode;
                        hold_cnt  <= '0;
                        o_index   <= 16'd0;
                        o_pattern <= next_pat;
                        o_strobe  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!i_pause) begin
                        if (hold_cnt == HOLD_LAST) begin
                            if (o_index == LAST_IDX) begin
                                // Final pattern and index stay on the outputs in DONE.
                                state <= ST_DONE;
                            end else begin
                                hold_cnt  <= '0;
                                o_index   <= next_idx;
                                o_pattern <= next_pat;
                                o_strobe  <= 1'b1;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + CW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy = (state == ST_RUN);
    assign o_done = (state == ST_DONE);

endmodule
